// File: rtl/unsigned_seq_div_rs_pkg.sv
// Shared definitions for the lab's sequential arithmetic blocks (multiplier and divider).
package seq_arith_pkg;

    // Default operand widths, shared with the 6x6 right-shift multiplier.
    localparam int DW_N_DEF = 12;
    localparam int DW_D_DEF = 6;

    // Control states of the sequential divider.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Width of an iteration counter that must be able to hold the value n.
    function automatic int iter_width(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int ITER_W_DEF = iter_width(DW_N_DEF);

endpackage

// File: rtl/unsigned_seq_div_rs_if.sv
// Operand/result bundle between a requester and the sequential divider.
interface unsigned_seq_div_rs_if #(
    parameter int DW_N = 12,
    parameter int DW_D = 6
);
    logic            load;
    logic [DW_N-1:0] a;
    logic [DW_D-1:0] b;
    logic [DW_N-1:0] quotient;
    logic [DW_D-1:0] remainder;
    logic            busy;
    logic            done;
    logic            div_zero;

    modport master (
        output load, a, b,
        input  quotient, remainder, busy, done, div_zero
    );

    modport slave (
        input  load, a, b,
        output quotient, remainder, busy, done, div_zero
    );
endinterface

// File: rtl/unsigned_seq_div_rs_step_tick_gen.sv
// Step prescaler: a one-cycle clock-enable pulse every STEP_DIV clocks, so the
// divider can be slowed down for the board without deriving a second clock.
module step_tick_gen #(
    parameter int STEP_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    logic [CW-1:0] cnt;

    // The pulse is high during the last cycle of each period, so the first
    // enabled edge lands exactly STEP_DIV clocks after the clearing edge.
    assign tick = (cnt == CW'(STEP_DIV - 1));

    // Period counter, restarted by reset or by a new division.
    always_ff @(posedge clk) begin
        // NOTE: registers are updated with <= so every flop samples the
        // pre-edge values; blocking = here would create order-dependent races.
        if (rst || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/unsigned_seq_div_rs.sv
// Sequential unsigned restoring divider: one quotient bit per step tick.
module unsigned_seq_div_rs
    import seq_arith_pkg::*;
#(
    parameter int DW_N     = DW_N_DEF,
    parameter int DW_D     = DW_D_DEF,
    parameter int STEP_DIV = 1
) (
    input logic                  clk,
    input logic                  rst,
    unsigned_seq_div_rs_if.slave bus
);
    localparam int ITER_W = iter_width(DW_N);

    div_state_e      state;
    logic [DW_N-1:0] dvd;        // dividend, shifted out MSB first
    logic [DW_D-1:0] dsr;        // captured divisor
    logic [DW_D:0]   r;          // partial remainder, one bit wider than the divisor
    logic [ITER_W-1:0] iter;
    logic [DW_N-1:0] quotient;
    logic [DW_D-1:0] remainder;
    logic            busy;
    logic            done;
    logic            div_zero;
    logic            tick;

    logic [DW_D:0]   r_shift;
    logic [DW_D:0]   r_next;
    logic            q_bit;

    step_tick_gen #(.STEP_DIV(STEP_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.load),
        .tick (tick)
    );

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        // NOTE: every output of this block gets a value before any branch,
        // so no path leaves one unassigned and no latch is inferred.
        r_shift = {r[DW_D-1:0], dvd[DW_N-1]};
        q_bit   = (r_shift >= {1'b0, dsr});
        r_next  = r_shift;
        if (q_bit) begin
            r_next = r_shift - {1'b0, dsr};
        end
    end

    // Control FSM and datapath registers; reset beats load beats stepping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dvd       <= '0;
            dsr       <= '0;
            r         <= '0;
            iter      <= '0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
        end else if (bus.load) begin
            dvd       <= bus.a;
            dsr       <= bus.b;
            r         <= '0;
            iter      <= '0;
            remainder <= '0;
            if (bus.b == '0) begin
                // Division by zero finishes at once with a saturated quotient.
                state    <= DONE;
                quotient <= '1;
                busy     <= 1'b0;
                done     <= 1'b1;
                div_zero <= 1'b1;
            end else begin
                state    <= RUN;
                quotient <= '0;
                busy     <= 1'b1;
                done     <= 1'b0;
                div_zero <= 1'b0;
            end
        end else if (state == RUN && tick) begin
            r        <= r_next;
            dvd      <= {dvd[DW_N-2:0], 1'b0};
            quotient <= {quotient[DW_N-2:0], q_bit};
            iter     <= iter + 1'b1;
            if (iter == ITER_W'(DW_N - 1)) begin
                // Last step: the restored remainder is below the divisor and fits DW_D bits.
                state     <= DONE;
                remainder <= r_next[DW_D-1:0];
                busy      <= 1'b0;
                done      <= 1'b1;
            end
        end
    end

    assign bus.quotient  = quotient;
    assign bus.remainder = remainder;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.div_zero  = div_zero;
endmodule
